// File: rtl/ctrl_fsm.sv
// Multicycle instruction control unit: latches one instruction at a time and
// sequences DECODE/EXEC/MEM/WB with Moore control strobes and a retire counter.
module ctrl_fsm #(
    parameter int INSTR_W = 16,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic [3:0]         opcode,
    output logic               alu_en,
    output logic               alu_src,
    output logic               mem_read,
    output logic               mem_write,
    output logic               reg_write,
    output logic               done,
    output logic               halted,
    output logic [CNT_W-1:0]   retired
);

    // state    | meaning
    // S_IDLE   | waiting for an instruction, instr_ready=1
    // S_DECODE | opcode latched, classify; no strobes
    // S_EXEC   | ALU cycle; BRANCH retires here
    // S_MEM    | data-memory access; STORE retires here
    // S_WB     | register-file write; R/I-type and LOAD retire here
    // S_HALT   | HALT executed, parked until reset
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [INSTR_W-1:0] ir;
    logic               accept;

    logic is_rtype;
    logic is_itype;
    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_halt;
    logic uses_imm;

    // The operand fields of ir are held for downstream use but not decoded here.
    logic unused_ir_bits;
    assign unused_ir_bits = ^ir[INSTR_W-5:0];

    assign opcode = ir[INSTR_W-1 -: 4];

    always_comb begin
        is_rtype  = (opcode[3] == 1'b0);
        is_itype  = (opcode[3:2] == 2'b10);
        is_load   = (opcode == 4'b1100);
        is_store  = (opcode == 4'b1101);
        is_branch = (opcode == 4'b1110);
        is_halt   = (opcode == 4'b1111);
        uses_imm  = is_itype || is_load || is_store;
    end

    // Reset forces ready low so an instruction presented during reset is never taken.
    assign instr_ready = (state == S_IDLE) && rst_n;
    assign accept      = instr_ready && instr_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            ir      <= '0;
            retired <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                ir <= instr;
            end
            if (done) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (instr_valid) begin
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_halt) begin
                    state_nxt = S_HALT;
                end else begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_branch || is_halt) begin
                    state_nxt = S_IDLE;
                end else if (is_load || is_store) begin
                    state_nxt = S_MEM;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_MEM: begin
                if (is_load) begin
                    state_nxt = S_WB;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_WB:    state_nxt = S_IDLE;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        alu_en    = 1'b0;
        alu_src   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        done      = 1'b0;
        halted    = 1'b0;
        case (state)
            S_EXEC: begin
                alu_en  = 1'b1;
                alu_src = uses_imm;
                done    = is_branch;
            end
            S_MEM: begin
                alu_src   = uses_imm;
                mem_read  = is_load;
                mem_write = is_store;
                done      = is_store;
            end
            S_WB: begin
                alu_src   = uses_imm;
                reg_write = is_rtype || is_itype || is_load;
                done      = 1'b1;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                alu_en = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ctrl_fsm.sv
// Directed bench for ctrl_fsm: a per-cycle expected-output scoreboard is filled
// from an instruction-class model and compared one entry per clock.
module tb_ctrl_fsm;

    logic        clk;
    logic        rst_n;
    logic [15:0] instr;
    logic        instr_valid;

    logic        instr_ready;
    logic [3:0]  opcode;
    logic        alu_en, alu_src, mem_read, mem_write, reg_write, done, halted;
    logic [15:0] retired;

    logic        w_instr_ready;
    logic [3:0]  w_opcode;
    logic        w_alu_en, w_alu_src, w_mem_read, w_mem_write, w_reg_write, w_done, w_halted;
    logic [3:0]  w_retired;

    ctrl_fsm #(.INSTR_W(16), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .opcode(opcode), .alu_en(alu_en), .alu_src(alu_src),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .done(done), .halted(halted), .retired(retired)
    );

    ctrl_fsm #(.INSTR_W(16), .CNT_W(4)) dut_w4 (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(w_instr_ready), .opcode(w_opcode), .alu_en(w_alu_en), .alu_src(w_alu_src),
        .mem_read(w_mem_read), .mem_write(w_mem_write), .reg_write(w_reg_write),
        .done(w_done), .halted(w_halted), .retired(w_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        ready;
        logic [3:0]  op;
        logic        alu_en;
        logic        alu_src;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        done;
        logic        halted;
        logic [15:0] r16;
        logic [3:0]  r4;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [31:0] m_ret    = 0;
    logic [3:0]  m_op     = 4'h0;

    function automatic exp_t mk(input logic rdy, input logic ae, input logic src,
                                input logic mr, input logic mw, input logic rw,
                                input logic dn, input logic hl);
        exp_t e;
        e.ready     = rdy;
        e.op        = m_op;
        e.alu_en    = ae;
        e.alu_src   = src;
        e.mem_read  = mr;
        e.mem_write = mw;
        e.reg_write = rw;
        e.done      = dn;
        e.halted    = hl;
        e.r16       = m_ret[15:0];
        e.r4        = m_ret[3:0];
        return e;
    endfunction

    task automatic tick(input string tag);
        exp_t e;
        exp_t a;
        @(posedge clk);
        #1;
        cyc++;
        a.ready     = instr_ready;
        a.op        = opcode;
        a.alu_en    = alu_en;
        a.alu_src   = alu_src;
        a.mem_read  = mem_read;
        a.mem_write = mem_write;
        a.reg_write = reg_write;
        a.done      = done;
        a.halted    = halted;
        a.r16       = retired;
        a.r4        = w_retired;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s cyc=%0d observed=%h expected=<scoreboard empty>", tag, cyc, a);
        end else begin
            e = sb.pop_front();
            assert (a === e) else begin
                failures++;
                $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, a, e);
            end
        end
    endtask

    // Expected vectors for the cycles after the acceptance edge, through the done cycle
    // (or the first HALT cycle).
    task automatic gen_seq(input logic [15:0] w, output int len);
        logic [3:0] o;
        logic       ld, st, br, ht, src;
        o   = w[15:12];
        ld  = (o == 4'hC);
        st  = (o == 4'hD);
        br  = (o == 4'hE);
        ht  = (o == 4'hF);
        src = (o[3:2] == 2'b10) || ld || st;
        m_op = o;
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        len = 1;
        if (ht) begin
            sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
            len = 2;
            return;
        end
        sb.push_back(mk(0, 1, src, 0, 0, 0, br, 0));
        len = 2;
        if (br) begin
            m_ret++;
            return;
        end
        if (ld || st) begin
            sb.push_back(mk(0, 0, src, ld, st, 0, st, 0));
            len = 3;
            if (st) begin
                m_ret++;
                return;
            end
        end
        sb.push_back(mk(0, 0, src, 0, 0, 1, 1, 0));
        len++;
        m_ret++;
    endtask

    task automatic issue(input logic [15:0] w, input logic keep, input logic [15:0] nxt,
                         input string tag);
        int len;
        instr       = w;
        instr_valid = 1'b1;
        gen_seq(w, len);
        tick(tag);
        if (keep) instr = nxt;
        else instr_valid = 1'b0;
        repeat (len - 1) tick(tag);
    endtask

    task automatic idle(input int n, input string tag);
        repeat (n) begin
            sb.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
            tick(tag);
        end
    endtask

    task automatic do_reset(input int n);
        rst_n       = 1'b0;
        instr_valid = 1'b1;
        instr       = 16'hF000;
        m_ret       = 0;
        m_op        = 4'h0;
        repeat (n) begin
            sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
            tick("reset");
        end
        rst_n       = 1'b0;
        rst_n       = 1'b1;
        instr_valid = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        instr       = 16'h0000;
        instr_valid = 1'b0;

        // Reset with a HALT presented: must be ignored, outputs all clear.
        do_reset(2);
        idle(1, "post_reset");

        // R-type, with junk on instr while idle to show it is ignored.
        issue(16'h3123, 1'b0, 16'h0, "rtype");
        instr = 16'hF0F0;
        idle(2, "rtype_idle");

        // LOAD then STORE back-to-back with instr_valid held high.
        do_reset(1);
        idle(1, "b2b_idle");
        issue(16'hC000, 1'b1, 16'hD000, "b2b_load");
        idle(1, "b2b_gap");
        issue(16'hD000, 1'b0, 16'h0, "b2b_store");
        idle(1, "b2b_end");

        // Every opcode, each followed by a reset.
        for (int op = 0; op < 16; op++) begin
            logic [15:0] w;
            w = {op[3:0], 12'($urandom)};
            do_reset(1);
            idle(1, "sweep_idle");
            if (op == 15) begin
                issue(w, 1'b1, 16'h1000, "sweep_halt");
                repeat (4) begin
                    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
                    tick("halt_hold");
                end
                instr_valid = 1'b0;
            end else begin
                issue(w, 1'b0, 16'h0, "sweep");
                idle(1, "sweep_done");
            end
        end

        // Reset arrives while a LOAD is in EXEC.
        do_reset(1);
        idle(1, "abort_idle");
        begin
            int len;
            instr       = 16'hC000;
            instr_valid = 1'b1;
            gen_seq(16'hC000, len);
            tick("abort_decode");
            instr_valid = 1'b0;
            tick("abort_exec");
            sb.delete();
        end
        do_reset(1);
        issue(16'h5ABC, 1'b0, 16'h0, "abort_next");
        idle(1, "abort_end");

        // Sixteen BRANCHes: the 4-bit counter wraps 15 -> 0 on the last done.
        do_reset(1);
        idle(1, "wrap_idle");
        for (int k = 0; k < 16; k++) begin
            issue(16'hE000, 1'b1, 16'hE000, "wrap_branch");
            if (k == 15) instr_valid = 1'b0;
            idle(1, "wrap_gap");
        end
        idle(1, "wrap_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
